// File: rtl/mips_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the mips_imem_loader boot loader.
// master = loader side, slave = stream source / memory / core side.
interface mips_imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              load_done;
    logic              err;

    modport master (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, core_run, load_done, err
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_run, load_done, err
    );
endinterface

// File: rtl/mips_imem_loader.sv
// Boot loader: framed byte stream (A5, N, 4N big-endian bytes) -> instruction-memory writes, then core_run.
// Define MIPS_IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit data-byte sum after the words.
module mips_imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mips_imem_loader_if.master  bus
);
    localparam int          CW  = ADDR_W + 1;
    localparam int unsigned CAP = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WAIT,
        S_DONE,
        S_ERROR
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     widx_q, widx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif
    logic              in_ready;
    logic              hs;

    // Ready depends on registered state only, never on in_valid.
    assign in_ready       = (state_q != S_WAIT) && (state_q != S_DONE);
    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_run   = (state_q == S_DONE);
    assign bus.load_done  = (state_q == S_DONE);
    assign bus.err        = (state_q == S_ERROR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        hs      = bus.in_valid && in_ready;

        case (state_q)
            S_IDLE: begin
                if (hs && bus.in_data == 8'hA5) state_d = S_COUNT;
            end
            S_COUNT: begin
                if (hs) begin
                    if (bus.in_data == 8'd0 || 32'(bus.in_data) > CAP) begin
                        state_d = S_ERROR;
                    end else begin
                        cnt_d   = CW'(bus.in_data);
                        widx_d  = '0;
                        bcnt_d  = '0;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
                        sum_d   = '0;
`endif
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (hs) begin
                    asm_d  = {asm_q[15:0], bus.in_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + bus.in_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = widx_q[ADDR_W-1:0];
                        wdata_d = {asm_q, bus.in_data};
                        // Extra index bit keeps N == 2**ADDR_W from wrapping to 0 here.
                        widx_d  = widx_q + CW'(1);
                        if (widx_d == cnt_q) begin
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHECK;
`else
                            state_d = S_WAIT;
`endif
                        end
                    end
                end
            end
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (hs) state_d = (bus.in_data == sum_q) ? S_WAIT : S_ERROR;
            end
`endif
            // Final write strobe is high during WAIT, so it commits before core_run rises.
            S_WAIT:  state_d = S_DONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MIPS_IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule
